// File: rtl/dl_sequencer.sv
// Download sequencer and core-reset scheduler.
// Routes HPS download writes to the ROM port, the variant byte or the DIP
// bank. It keeps the game core in reset while the ROM loads and for a settle
// period after the load ends. It also stretches user reset requests.
// Optional feature: define DL_DIP_BANK_EN to build the writable DIP bank.
// Without it, dip_bank is tied to all-ones.
module dl_sequencer #(
  parameter int          SETTLE_CYCLES = 1024,
  parameter logic [16:0] ROM_BYTES     = 17'h10000
) (
  input  logic        clk_sys,
  input  logic        RESET,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [7:0]  ioctl_index,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  input  logic        user_reset,
  output logic        rom_wr,
  output logic [15:0] rom_addr,
  output logic [7:0]  rom_data,
  output logic [7:0]  mod_id,
  output logic [31:0] dip_bank,
  output logic        core_reset,
  output logic        rom_ready
);

  typedef enum logic [1:0] {IDLE, LOAD, SETTLE, RUN} state_t;

  localparam logic [15:0] RELOAD = 16'(SETTLE_CYCLES - 1);

  state_t      state;
  logic [16:0] byte_cnt;
  logic [15:0] settle_cnt;

  logic        load_start;
  logic        in_load;
  logic        rom_take;
  logic [16:0] addr_end;
  logic [16:0] cnt_base;
  logic [16:0] cnt_new;

  // A new ROM download restarts from LOAD in any state. A write in the
  // entry cycle counts against a freshly cleared byte counter.
  always_comb begin
    load_start = ioctl_download && (ioctl_index == 8'd0) && (state != LOAD);
    in_load    = (state == LOAD) || load_start;
    rom_take   = in_load && ioctl_wr && (ioctl_index == 8'd0) &&
                 (ioctl_addr[24:16] == 9'd0);
    addr_end   = {1'b0, ioctl_addr[15:0]} + 17'd1;
    cnt_base   = load_start ? 17'd0 : byte_cnt;
    cnt_new    = (rom_take && (addr_end > cnt_base)) ? addr_end : cnt_base;
  end

  // Sequencer: ROM forwarding, image-size tracking and core reset scheduling.
  always_ff @(posedge clk_sys or posedge RESET) begin
    if (RESET) begin
      state      <= IDLE;
      rom_wr     <= 1'b0;
      rom_addr   <= 16'd0;
      rom_data   <= 8'd0;
      core_reset <= 1'b1;
      rom_ready  <= 1'b0;
      byte_cnt   <= 17'd0;
      settle_cnt <= 16'd0;
    end else begin
      rom_wr   <= rom_take;
      byte_cnt <= cnt_new;
      if (rom_take) begin
        rom_addr <= ioctl_addr[15:0];
        rom_data <= ioctl_dout;
      end
      if (load_start) begin
        state      <= LOAD;
        rom_ready  <= 1'b0;
        core_reset <= 1'b1;
      end else begin
        case (state)
          IDLE: core_reset <= 1'b1;
          LOAD: begin
            if (!ioctl_download) begin
              state      <= SETTLE;
              settle_cnt <= RELOAD;
              rom_ready  <= (cnt_new >= ROM_BYTES);
            end
          end
          SETTLE: begin
            // A held user reset keeps reloading, so the countdown only
            // starts once the request drops.
            if (user_reset) begin
              settle_cnt <= RELOAD;
            end else if (settle_cnt == 16'd0) begin
              state      <= rom_ready ? RUN : IDLE;
              core_reset <= !rom_ready;
            end else begin
              settle_cnt <= settle_cnt - 16'd1;
            end
          end
          RUN: begin
            if (user_reset) begin
              state      <= SETTLE;
              settle_cnt <= RELOAD;
              core_reset <= 1'b1;
            end
          end
          default: begin
            state      <= IDLE;
            core_reset <= 1'b1;
          end
        endcase
      end
    end
  end

  // Variant byte: only address 0 of index 1 is meaningful.
  always_ff @(posedge clk_sys or posedge RESET) begin
    if (RESET) begin
      mod_id <= 8'd0;
    end else if (ioctl_wr && (ioctl_index == 8'd1) && (ioctl_addr == 25'd0)) begin
      mod_id <= ioctl_dout;
    end
  end

`ifdef DL_DIP_BANK_EN
  // DIP bank: four byte lanes addressed by ioctl_addr[1:0], any state.
  always_ff @(posedge clk_sys or posedge RESET) begin
    if (RESET) begin
      dip_bank <= 32'hFFFF_FFFF;
    end else if (ioctl_wr && (ioctl_index == 8'd254) &&
                 (ioctl_addr[24:2] == 23'd0)) begin
      dip_bank[ioctl_addr[1:0]*8 +: 8] <= ioctl_dout;
    end
  end
`else
  assign dip_bank = 32'hFFFF_FFFF;
`endif

endmodule
